// File: rtl/seq_func_pkg.sv
// Shared mode encodings and parameter defaults for the sequential function unit.
package seq_func_pkg;

  localparam int unsigned W_DEFAULT  = 4;
  localparam int unsigned CW_DEFAULT = 8;

  typedef enum logic [1:0] {
    MODE_ANDOR = 2'd0,
    MODE_XNOR3 = 2'd1,
    MODE_MAJ3  = 2'd2,
    MODE_ACC   = 2'd3
  } mode_e;

endpackage

// File: rtl/seq_func_unit_core.sv
// Combinational mode logic: AND-OR, XNOR3, majority and parity-accumulate result.
module func_core
  import seq_func_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [W-1:0]   C,
  input  logic [3*W-1:0] D,
  input  logic [1:0]     Sel,
  input  logic [W-1:0]   acc,
  output logic [W-1:0]   result
);

  logic [W-1:0] d0, d1, d2;

  assign d0 = D[W-1:0];
  assign d1 = D[2*W-1:W];
  assign d2 = D[3*W-1:2*W];

  always_comb begin
    result = '0;
    case (mode_e'(Sel))
      MODE_ANDOR: result = (d0 & d1) | d2;
      MODE_XNOR3: result = ~(A ^ B ^ C);
      MODE_MAJ3:  result = (A & B) | (B & C) | (A & C);
      // With acc held at zero this collapses to the XNOR3 result.
      MODE_ACC:   result = ~(acc ^ A ^ B ^ C);
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/seq_func_unit.sv
// Registered function unit with valid/ready handshake and optional parity accumulator.
// Accumulate mode (acc and Count registers) is built only when SEQ_FUNC_ACC_EN is defined.
module seq_func_unit
  import seq_func_pkg::*;
#(
  parameter int unsigned W  = W_DEFAULT,
  parameter int unsigned CW = CW_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [W-1:0]   C,
  input  logic [3*W-1:0] D,
  input  logic [1:0]     Sel,
  input  logic           Last,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   Out,
  output logic [W-1:0]   Out_bar,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CW-1:0]  Count
);

  logic [W-1:0] out_q, out_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] result;
  logic [W-1:0] acc_w;
  logic         stall;
  logic         accept;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  func_core #(.W(W)) u_core (
    .A      (A),
    .B      (B),
    .C      (C),
    .D      (D),
    .Sel    (Sel),
    .acc    (acc_w),
    .result (result)
  );

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_d       = result;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Out       = out_q;
  assign Out_bar   = ~out_q;
  assign out_valid = out_valid_q;

`ifdef SEQ_FUNC_ACC_EN
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] count_q, count_d, count_base;
  logic          clr_pend_q, clr_pend_d;
  logic          acc_beat;

  assign acc_beat = accept && (Sel == MODE_ACC);

  // A Last beat stays visible on Count for its Out cycle; the clear is
  // deferred via clr_pend and applied on the next non-stalled cycle.
  always_comb begin
    acc_d      = acc_q;
    count_d    = count_q;
    clr_pend_d = clr_pend_q;
    count_base = clr_pend_q ? '0 : count_q;
    if (!stall) begin
      count_d    = count_base;
      clr_pend_d = 1'b0;
    end
    if (acc_beat) begin
      acc_d      = Last ? '0 : (acc_q ^ A ^ B ^ C);
      count_d    = (count_base == '1) ? count_base : count_base + CW'(1);
      clr_pend_d = Last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      count_q    <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      count_q    <= count_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  assign acc_w = acc_q;
  assign Count = count_q;
`else
  logic unused_last;

  assign unused_last = Last;
  assign acc_w       = '0;
  assign Count       = '0;
`endif

endmodule

// File: tb/tb_seq_func_unit.sv
// Directed and randomized self-checking bench for seq_func_unit (W=4, CW=8).
module tb_seq_func_unit;

`ifdef SEQ_FUNC_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  A, B, C;
  logic [11:0] D;
  logic [1:0]  Sel;
  logic        Last;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Out, Out_bar;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  Count;

  int n_checks = 0;
  int n_pass   = 0;

  seq_func_unit #(.W(4), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .Sel       (Sel),
    .Last      (Last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Out       (Out),
    .Out_bar   (Out_bar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Count     (Count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    Sel = 2'd1; A = 4'h3; B = 4'h0; C = 4'h0; D = 12'h0; Last = 1'b0;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++;
    if (Out !== 4'h0) $display("FAIL reset_out: got %h expected 0", Out); else n_pass++;
    n_checks++;
    if (Out_bar !== 4'hF) $display("FAIL reset_out_bar: got %h expected f", Out_bar); else n_pass++;
    n_checks++;
    if (Count !== 8'd0) $display("FAIL reset_count: got %0d expected 0", Count); else n_pass++;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    out_ready = 1'b1;
  endtask

  task automatic test_andor();
    Sel = 2'd0; D = {4'b0001, 4'b1010, 4'b1100}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (Out !== 4'b1001) $display("FAIL andor_out: got %b expected 1001", Out); else n_pass++;
    n_checks++;
    if (Out_bar !== 4'b0110) $display("FAIL andor_out_bar: got %b expected 0110", Out_bar); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL andor_valid: got %b expected 1", out_valid); else n_pass++;
    // Inputs changing with in_valid low must leave the result untouched.
    D = 12'hFFF; A = 4'hA;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || Out !== 4'b1001)
      $display("FAIL idle_hold: got valid=%b out=%b expected valid=0 out=1001", out_valid, Out);
    else n_pass++;
  endtask

  task automatic test_xnor_maj();
    A = 4'hF; B = 4'h0; C = 4'h5; Sel = 2'd1; in_valid = 1'b1;
    tick();
    n_checks++;
    if (Out !== 4'h5) $display("FAIL xnor3_out: got %h expected 5", Out); else n_pass++;
    Sel = 2'd2;
    tick();
    n_checks++;
    if (Out !== 4'h5 || out_valid !== 1'b1)
      $display("FAIL maj3_out: got out=%h valid=%b expected out=5 valid=1", Out, out_valid);
    else n_pass++;
    A = 4'hC; B = 4'hA; C = 4'h6;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (Out !== 4'hE) $display("FAIL maj3_out2: got %h expected e", Out); else n_pass++;
    tick();
  endtask

`ifdef SEQ_FUNC_ACC_EN
  task automatic test_acc();
    Sel = 2'd3; B = 4'h0; C = 4'h0; Last = 1'b0; in_valid = 1'b1; A = 4'h1;
    tick();
    n_checks++;
    if (Out !== 4'hE || Count !== 8'd1) $display("FAIL acc_beat1: got out=%h count=%0d expected out=e count=1", Out, Count); else n_pass++;
    A = 4'h2;
    tick();
    n_checks++;
    if (Out !== 4'hC || Count !== 8'd2) $display("FAIL acc_beat2: got out=%h count=%0d expected out=c count=2", Out, Count); else n_pass++;
    A = 4'h4; Last = 1'b1;
    tick();
    n_checks++;
    if (Out !== 4'h8 || Count !== 8'd3) $display("FAIL acc_beat3: got out=%h count=%0d expected out=8 count=3", Out, Count); else n_pass++;
    in_valid = 1'b0; Last = 1'b0;
    tick();
    n_checks++;
    if (Count !== 8'd0 || out_valid !== 1'b0) $display("FAIL acc_clear: got count=%0d valid=%b expected count=0 valid=0", Count, out_valid); else n_pass++;
    // New group starts from a cleared accumulator.
    A = 4'h6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (Out !== 4'h9 || Count !== 8'd1) $display("FAIL acc_regroup: got out=%h count=%0d expected out=9 count=1", Out, Count); else n_pass++;
    Last = 1'b1; A = 4'h0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; Last = 1'b0;
    tick();
  endtask
`else
  task automatic test_acc_disabled();
    Sel = 2'd3; A = 4'hF; B = 4'h0; C = 4'h0; Last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; Last = 1'b0;
    n_checks++;
    if (Out !== 4'h0 || Count !== 8'd0) $display("FAIL acc_disabled: got out=%h count=%0d expected out=0 count=0", Out, Count); else n_pass++;
    tick();
  endtask
`endif

  task automatic test_back_to_back();
    Sel = 2'd0; D = {4'h1, 4'h0, 4'h0}; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    n_checks++;
    if (Out !== 4'h1 || out_valid !== 1'b1) $display("FAIL bp_first: got out=%h valid=%b expected out=1 valid=1", Out, out_valid); else n_pass++;
    out_ready = 1'b0; D = {4'h2, 4'h0, 4'h0};
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", in_ready); else n_pass++;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (Out !== 4'h1 || Out_bar !== 4'hE || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_hold: got out=%h bar=%h valid=%b rdy=%b expected out=1 bar=e valid=1 rdy=0", Out, Out_bar, out_valid, in_ready);
      else n_pass++;
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (Out !== 4'h2 || out_valid !== 1'b1) $display("FAIL bp_release: got out=%h valid=%b expected out=2 valid=1", Out, out_valid); else n_pass++;
    D = {4'h3, 4'h0, 4'h0};
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (Out !== 4'h3 || out_valid !== 1'b1) $display("FAIL bp_next: got out=%h valid=%b expected out=3 valid=1", Out, out_valid); else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_drain: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_group();
    Sel = 2'd3; B = 4'h0; C = 4'h0; Last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    A = 4'h1; tick();
    A = 4'h2; tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || Out !== 4'h0 || Out_bar !== 4'hF || Count !== 8'd0)
      $display("FAIL rst_mid: got valid=%b out=%h bar=%h count=%0d expected valid=0 out=0 bar=f count=0", out_valid, Out, Out_bar, Count);
    else n_pass++;
    rst = 1'b0; A = 4'h3;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (Out !== 4'hC || Count !== (ACC_EN ? 8'd1 : 8'd0))
      $display("FAIL rst_mid_after: got out=%h count=%0d expected out=c count=%0d", Out, Count, ACC_EN ? 1 : 0);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] m_out, m_acc, res, nxt;
    logic       m_valid, m_pend, m_stall, m_accept;
    logic [7:0] m_cnt;
    logic [3:0] d0, d1, d2;
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    m_out = 4'h0; m_valid = 1'b0; m_acc = 4'h0; m_cnt = 8'd0; m_pend = 1'b0;
    for (int i = 0; i < 300; i++) begin
      A = 4'($urandom); B = 4'($urandom); C = 4'($urandom); D = 12'($urandom);
      Sel = 2'($urandom); Last = ($urandom_range(0, 3) == 0);
      in_valid = ($urandom_range(0, 3) != 0); out_ready = ($urandom_range(0, 2) != 0);
      #1;
      n_checks++;
      if (in_ready !== (!m_valid || out_ready))
        $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, in_ready, !m_valid || out_ready);
      else n_pass++;
      d0 = D[3:0]; d1 = D[7:4]; d2 = D[11:8];
      nxt = m_acc ^ A ^ B ^ C;
      case (Sel)
        2'd0:    res = (d0 & d1) | d2;
        2'd1:    res = ~(A ^ B ^ C);
        2'd2:    res = (A & B) | (B & C) | (A & C);
        default: res = ACC_EN ? ~nxt : ~(A ^ B ^ C);
      endcase
      m_stall  = m_valid && !out_ready;
      m_accept = in_valid && !m_stall;
      tick();
      if (!m_stall && m_pend) begin
        m_cnt = 8'd0; m_pend = 1'b0;
      end
      if (m_accept) begin
        m_out = res; m_valid = 1'b1;
        if (ACC_EN && Sel == 2'd3) begin
          m_acc = Last ? 4'h0 : nxt;
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
          m_pend = Last;
        end
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      n_checks++;
      if (out_valid !== m_valid || Out !== m_out || Out_bar !== ~m_out || Count !== m_cnt)
        $display("FAIL rand_out[%0d]: got valid=%b out=%h bar=%h count=%0d expected valid=%b out=%h bar=%h count=%0d",
                 i, out_valid, Out, Out_bar, Count, m_valid, m_out, ~m_out, m_cnt);
      else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_andor();
    test_xnor_maj();
`ifdef SEQ_FUNC_ACC_EN
    test_acc();
`else
    test_acc_disabled();
`endif
    test_back_to_back();
    test_reset_mid_group();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_func_unit.md
SEQ_FUNC_UNIT -- requirements
Module: seq_func_unit

Interface
REQ-001 Parameter W, default 4: operand and result width in bits, legal range 1..32.
REQ-002 Parameter CW, default 8: beat-counter width in bits, legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 A, B, C  input  W each  operands for XNOR3, majority and accumulate modes.
REQ-006 D  input  3*W  D[W-1:0]=D0, D[2W-1:W]=D1, D[3W-1:2W]=D2, operands for AND-OR mode.
REQ-007 Sel  input  2  mode: 0 AND-OR, 1 XNOR3, 2 MAJ3, 3 ACC (parity accumulate).
REQ-008 Last  input  1  marks the final ACC beat of a group; ignored outside ACC mode.
REQ-009 in_valid  input  1 / in_ready  output  1  input handshake.
REQ-010 Out, Out_bar  output  W each  registered result and its bitwise complement.
REQ-011 out_valid  output  1 / out_ready  input  1  output handshake.
REQ-012 Count  output  CW  accepted ACC beats since the last group clear.

Function
REQ-013 A beat SHALL be accepted when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational, no other dependency).
REQ-014 An accepted beat SHALL appear on Out/out_valid exactly 1 cycle later; latency 1, throughput 1 beat/cycle when out_ready is held high.
REQ-015 Mode 0: Out = (D0 & D1) | D2, bitwise.
REQ-016 Mode 1: Out = ~(A ^ B ^ C), bitwise.
REQ-017 Mode 2: Out = (A&B) | (B&C) | (A&C), bitwise.
REQ-018 Mode 3: acc_next = acc ^ A ^ B ^ C; Out = ~acc_next; acc <= acc_next, or 0 if Last=1.
REQ-019 Count SHALL increment on each accepted ACC beat, saturate at 2^CW-1, and clear to 0 after an accepted beat with Last=1 (the Last beat itself is counted in the Out cycle, then cleared the next).
REQ-020 Beats in modes 0-2 SHALL not modify acc or Count; an ACC group may be interleaved with other modes.
REQ-021 Out_bar SHALL equal ~Out in every cycle, including reset.
REQ-022 While out_valid && !out_ready, Out, Out_bar, out_valid and Count SHALL hold; no beat is accepted.
REQ-023 Simultaneous output consumption and input acceptance SHALL load the new result with out_valid staying 1.
REQ-024 Input changes while in_valid=0 SHALL have no effect on any state.

Reset
REQ-025 rst=1 at a clock edge SHALL set out_valid=0, Out=0, Out_bar=all-ones, acc=0, Count=0, regardless of handshake state.
REQ-026 Reset mid-group SHALL discard the partial ACC group; in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-027 Macro SEQ_FUNC_ACC_EN: defined -> mode 3 as REQ-018/019.
REQ-028 Undefined -> no acc or Count registers, Count tied to 0, Sel=3 behaves as mode 1 and Last is ignored.

Structure
REQ-029 Package seq_func_pkg SHALL hold the mode encodings (MODE_ANDOR, MODE_XNOR3, MODE_MAJ3, MODE_ACC) and parameter defaults.
REQ-030 Combinational mode logic SHALL live in sub-module func_core (inputs A, B, C, D, Sel, acc; output result); handshake, acc and Count registers in the top.

Verification (W=4, CW=8, SEQ_FUNC_ACC_EN defined unless stated)
REQ-031 Sel=0, D0=4'b1100, D1=4'b1010, D2=4'b0001, out_ready=1 -> next cycle Out=4'b1001, Out_bar=4'b0110, out_valid=1.
REQ-032 Sel=1, A=4'hF, B=4'h0, C=4'h5 -> Out=4'h5; Sel=2 same operands -> Out=4'h5.
REQ-033 Sel=3, beats A=4'h1, 4'h2, 4'h4 (B=C=0), third with Last=1 -> Out=4'hE, 4'hC, 4'h8; Count=1,2,3 then 0.
REQ-034 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, Out held; out_ready=1 -> one result per cycle, none lost or duplicated.
REQ-035 rst pulse after 2 ACC beats -> out_valid=0, Out=0, Out_bar=4'hF, Count=0; next ACC beat A=4'h3 -> Out=4'hC.
REQ-036 Macro undefined: Sel=3, A=4'hF, B=C=0 -> Out=4'h0, Count=0; 300 random beats vs reference model with random out_ready -> zero mismatches.
